// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module : seq_pkg
//  Brief  : Shared types and helpers for the serial pattern generator.
//  Rev    : 1.0
// ============================================================================
package seq_pkg;

   localparam int PAT_W_DEF = 8;
   localparam int LEN_W     = $clog2(PAT_W_DEF) + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // A length of zero or anything beyond the pattern register means "full width".
   function automatic int unsigned clamp_len(input int unsigned len_in,
                                             input int unsigned max_len);
      return ((len_in == 0) || (len_in > max_len)) ? max_len : len_in;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module : seq_pattern_gen
//  Brief  : Serial bit-pattern transmitter, MSB-first, repeated reps+1 times.
//  Rev    : 1.0
// ============================================================================
module seq_pattern_gen
   import seq_pkg::*;
#(
   parameter int   PAT_W    = 8,
   parameter int   REP_W    = 4,
   parameter logic IDLE_BIT = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [PAT_W-1:0]       pattern,
   input  logic [$clog2(PAT_W):0] len,
   input  logic [REP_W-1:0]       reps,
   input  logic                   abort,
   output logic                   ready,
   output logic                   x,
   output logic                   x_valid,
   output logic                   done
);

   localparam int LW = $clog2(PAT_W) + 1;
   localparam int IW = (PAT_W > 1) ? $clog2(PAT_W) : 1;

   state_t           state, state_n;
   logic [PAT_W-1:0] pat_q, pat_n;
   logic [IW-1:0]    last_q, last_n;
   logic [IW-1:0]    bit_idx, bit_n;
   logic [REP_W-1:0] rep_cnt, rep_n;
   logic             x_n, x_valid_n, done_n;
   logic [LW-1:0]    len_c;
   logic [IW-1:0]    last_in;

   always_comb begin
      len_c   = LW'(clamp_len(32'(len), PAT_W));
      last_in = IW'(len_c - LW'(1));
   end

   // Outputs are computed for the next cycle so x always shows pat_q[bit_idx] in SHIFT.
   always_comb begin
      state_n   = state;
      pat_n     = pat_q;
      last_n    = last_q;
      bit_n     = bit_idx;
      rep_n     = rep_cnt;
      x_n       = IDLE_BIT;
      x_valid_n = 1'b0;
      done_n    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && !abort) begin
               pat_n     = pattern;
               last_n    = last_in;
               bit_n     = last_in;
               rep_n     = reps;
               x_n       = pattern[last_in];
               x_valid_n = 1'b1;
               state_n   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (abort) begin
               state_n = ST_IDLE;
            end else if (bit_idx == '0) begin
               if (rep_cnt != '0) begin
                  rep_n     = rep_cnt - REP_W'(1);
                  bit_n     = last_q;
                  x_n       = pat_q[last_q];
                  x_valid_n = 1'b1;
               end else begin
                  state_n = ST_DONE;
                  done_n  = 1'b1;
               end
            end else begin
               bit_n     = bit_idx - IW'(1);
               x_n       = pat_q[bit_n];
               x_valid_n = 1'b1;
            end
         end
         ST_DONE: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         pat_q   <= '0;
         last_q  <= '0;
         bit_idx <= '0;
         rep_cnt <= '0;
         x       <= IDLE_BIT;
         x_valid <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         pat_q   <= pat_n;
         last_q  <= last_n;
         bit_idx <= bit_n;
         rep_cnt <= rep_n;
         x       <= x_n;
         x_valid <= x_valid_n;
         done    <= done_n;
      end
   end

   assign ready = (state == ST_IDLE);

endmodule
`default_nettype wire
